// File: rtl/line_engine.sv
// Bresenham line rasterizer: takes endpoint/color strobes plus a trigger and emits one
// framebuffer pixel-write request per pixel. Define LINE_ENGINE_CLIP_EN to suppress off-screen pixels.
module line_engine #(
    parameter logic [31:0] FB_BASE = 32'h1000_0000,
    parameter int          H_RES   = 800,
    parameter int          V_RES   = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] line_color,
    input  logic [9:0]  line_point,
    input  logic        line_color_valid,
    input  logic        line_x0_valid,
    input  logic        line_y0_valid,
    input  logic        line_x1_valid,
    input  logic        line_y1_valid,
    input  logic        line_trigger,
    output logic        line_ready,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [31:0] px_addr,
    output logic [23:0] px_color
);

`ifdef LINE_ENGINE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t state, state_next;

    logic [23:0] color_r;
    logic [9:0]  x0_r, y0_r, x1_r, y1_r;

    logic [9:0]         cur_x, cur_y, end_x;
    logic [10:0]        dx, dy;
    logic signed [11:0] err;
    logic               steep, ystep_neg;

    logic unused_color_bits;
    assign unused_color_bits = ^line_color[31:24];

    // Setup datapath: endpoints are folded into the x-major, left-to-right octant.
    logic [9:0]  adx, ady;
    logic        s_steep;
    logic [9:0]  ax0, ay0, ax1, ay1;
    logic [9:0]  bx0, by0, bx1, by1;
    logic [10:0] s_dx, s_dy;

    always_comb begin
        adx     = (x1_r >= x0_r) ? (x1_r - x0_r) : (x0_r - x1_r);
        ady     = (y1_r >= y0_r) ? (y1_r - y0_r) : (y0_r - y1_r);
        s_steep = ady > adx;
        ax0     = s_steep ? y0_r : x0_r;
        ay0     = s_steep ? x0_r : y0_r;
        ax1     = s_steep ? y1_r : x1_r;
        ay1     = s_steep ? x1_r : y1_r;
        if (ax0 > ax1) begin
            bx0 = ax1;
            by0 = ay1;
            bx1 = ax0;
            by1 = ay0;
        end else begin
            bx0 = ax0;
            by0 = ay0;
            bx1 = ax1;
            by1 = ay1;
        end
        s_dx = {1'b0, bx1 - bx0};
        s_dy = {1'b0, (by1 >= by0) ? (by1 - by0) : (by0 - by1)};
    end

    // Pixel output path: working coordinates are un-swapped back to screen order.
    logic [9:0]         scr_x, scr_y;
    logic               offscreen, advance, last_px;
    logic signed [11:0] err_step, err_wrap;

    always_comb begin
        scr_x     = steep ? cur_y : cur_x;
        scr_y     = steep ? cur_x : cur_y;
        offscreen = CLIP_EN && (({22'd0, scr_x} >= 32'(H_RES)) || ({22'd0, scr_y} >= 32'(V_RES)));
        px_valid  = (state == DRAW) && !offscreen;
        advance   = (state == DRAW) && (offscreen || px_ready);
        last_px   = cur_x == end_x;
        px_addr   = px_valid ? (FB_BASE + {10'd0, scr_y, 12'd0} + {20'd0, scr_x, 2'd0}) : 32'd0;
        px_color  = px_valid ? color_r : 24'd0;
        err_step  = err - $signed({1'b0, dy});
        err_wrap  = err_step + $signed({1'b0, dx});
        line_ready = state == IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (line_trigger) state_next = SETUP;
            SETUP:   state_next = DRAW;
            DRAW:    if (advance && last_px) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_r   <= 24'd0;
            x0_r      <= 10'd0;
            y0_r      <= 10'd0;
            x1_r      <= 10'd0;
            y1_r      <= 10'd0;
            cur_x     <= 10'd0;
            cur_y     <= 10'd0;
            end_x     <= 10'd0;
            dx        <= 11'd0;
            dy        <= 11'd0;
            err       <= 12'sd0;
            steep     <= 1'b0;
            ystep_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_color_valid) color_r <= line_color[23:0];
                    if (line_x0_valid)    x0_r    <= line_point;
                    if (line_y0_valid)    y0_r    <= line_point;
                    if (line_x1_valid)    x1_r    <= line_point;
                    if (line_y1_valid)    y1_r    <= line_point;
                end
                SETUP: begin
                    cur_x     <= bx0;
                    cur_y     <= by0;
                    end_x     <= bx1;
                    dx        <= s_dx;
                    dy        <= s_dy;
                    err       <= $signed({2'b00, s_dx[10:1]});
                    steep     <= s_steep;
                    ystep_neg <= !(by0 < by1);
                end
                DRAW: begin
                    if (advance && !last_px) begin
                        cur_x <= cur_x + 10'd1;
                        if (err_step < 0) begin
                            cur_y <= ystep_neg ? (cur_y - 10'd1) : (cur_y + 10'd1);
                            err   <= err_wrap;
                        end else begin
                            err   <= err_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_engine.sv
// Self-checking bench for line_engine: directed and random lines against a closed-form
// Bresenham pixel model, with backpressure, mid-line strobe rejection and reset abort.
module tb_line_engine;

    localparam logic [31:0] FB_BASE = 32'h1000_0000;
    localparam int          H_RES   = 800;
    localparam int          V_RES   = 600;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] line_color;
    logic [9:0]  line_point;
    logic        line_color_valid, line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid;
    logic        line_trigger;
    logic        line_ready;
    logic        px_valid;
    logic        px_ready;
    logic [31:0] px_addr;
    logic [23:0] px_color;

    line_engine #(.FB_BASE(FB_BASE), .H_RES(H_RES), .V_RES(V_RES)) dut (
        .clk(clk),
        .rst(rst),
        .line_color(line_color),
        .line_point(line_point),
        .line_color_valid(line_color_valid),
        .line_x0_valid(line_x0_valid),
        .line_y0_valid(line_y0_valid),
        .line_x1_valid(line_x1_valid),
        .line_y1_valid(line_y1_valid),
        .line_trigger(line_trigger),
        .line_ready(line_ready),
        .px_valid(px_valid),
        .px_ready(px_ready),
        .px_addr(px_addr),
        .px_color(px_color)
    );

    always #5 clk = ~clk;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] expQ[$];
    bit          firstVisible;
    bit          readyPat[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    function automatic int absDiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Model: pixel i along the major axis sits k_i minor steps from the start, where k_i is the
    // smallest count keeping the error term non-negative: ceil((i*dv - du/2) / du), floored at 0.
    task automatic buildExpected(input int x0, input int y0, input int x1, input int y1);
        int  u0, v0, u1, v1, t, du, dv, vs, e0, num, k, u, v, sx, sy;
        bit  st, vis;
        expQ.delete();
        st = absDiff(y1, y0) > absDiff(x1, x0);
        u0 = st ? y0 : x0;  v0 = st ? x0 : y0;
        u1 = st ? y1 : x1;  v1 = st ? x1 : y1;
        if (u0 > u1) begin
            t = u0; u0 = u1; u1 = t;
            t = v0; v0 = v1; v1 = t;
        end
        du = u1 - u0;
        dv = absDiff(v1, v0);
        vs = (v0 < v1) ? 1 : -1;
        e0 = du / 2;
        firstVisible = 1'b0;
        for (int i = 0; i <= du; i++) begin
            num = i * dv - e0;
            k   = (num <= 0) ? 0 : (num + du - 1) / du;
            u   = u0 + i;
            v   = v0 + vs * k;
            sx  = st ? v : u;
            sy  = st ? u : v;
            vis = 1'b1;
`ifdef LINE_ENGINE_CLIP_EN
            vis = (sx < H_RES) && (sy < V_RES);
`endif
            if (i == 0) firstVisible = vis;
            if (vis) expQ.push_back(FB_BASE + 32'(sy * 4096) + 32'(sx * 4));
        end
    endtask

    task automatic clearStrobes();
        line_color_valid = 1'b0;
        line_x0_valid    = 1'b0;
        line_y0_valid    = 1'b0;
        line_x1_valid    = 1'b0;
        line_y1_valid    = 1'b0;
        line_trigger     = 1'b0;
    endtask

    // readyMode: 0 = always ready, 1 = fixed 0,1,0,0,1 pattern, 2 = random
    task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                                 input logic [23:0] color, input int readyMode,
                                 input bit inject, input bit doStrobe);
        int  got, expCount, limit;
        bit  prevValid, stalled, finished;
        buildExpected(x0, y0, x1, y1);
        expCount = expQ.size();
        limit    = 4 * (absDiff(x1, x0) + absDiff(y1, y0)) + 40;
        @(negedge clk);
        if (doStrobe) begin
            line_color = {8'hA5, color}; line_color_valid = 1'b1;
            line_point = 10'(x0); line_x0_valid = 1'b1;
            @(negedge clk); clearStrobes();
            line_point = 10'(y0); line_y0_valid = 1'b1;
            @(negedge clk); clearStrobes();
            line_point = 10'(x1); line_x1_valid = 1'b1;
            @(negedge clk); clearStrobes();
            line_point = 10'(y1); line_y1_valid = 1'b1;
        end
        line_trigger = 1'b1;
        @(negedge clk);
        clearStrobes();
        checkOutput("setupReadyLow", 32'(line_ready), 32'd0);
        checkOutput("setupNoValid", 32'(px_valid), 32'd0);
        got = 0; prevValid = 1'b0; stalled = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < limit; cyc++) begin
            @(negedge clk);
            clearStrobes();
            if (cyc == 0 && firstVisible) checkOutput("firstValidT+2", 32'(px_valid), 32'd1);
            if (line_ready) begin
                finished = 1'b1;
                break;
            end
            if (stalled) checkOutput("stallHold", 32'(px_valid), 32'd1);
            case (readyMode)
                0:       px_ready = 1'b1;
                1:       px_ready = readyPat[cyc % 5];
                default: px_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (inject && cyc == 3) begin
                line_trigger  = 1'b1;
                line_x0_valid = 1'b1;
                line_point    = 10'd777;
            end
            if (px_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraPixel", 32'(px_valid), 32'd0);
                end else begin
                    checkOutput("addr", px_addr, expQ[0]);
                    checkOutput("color", 32'(px_color), 32'(color));
                    if (px_ready) begin
                        void'(expQ.pop_front());
                        got++;
                    end
                end
                stalled = !px_ready;
            end else begin
                stalled = 1'b0;
            end
            prevValid = px_valid;
        end
        if (!finished) checkOutput("timeout", 32'(line_ready), 32'd1);
        checkOutput("doneGap", 32'(prevValid), 32'd0);
        checkOutput("pixCount", 32'(got), 32'(expCount));
        px_ready = 1'b0;
        clearStrobes();
    endtask

    task automatic resetMidLine();
        @(negedge clk);
        line_color = 32'h0012_3456; line_color_valid = 1'b1;
        line_point = 10'd0; line_x0_valid = 1'b1; line_y0_valid = 1'b1; line_y1_valid = 1'b1;
        @(negedge clk); clearStrobes();
        line_point = 10'd100; line_x1_valid = 1'b1; line_trigger = 1'b1;
        px_ready = 1'b1;
        @(negedge clk); clearStrobes();
        @(negedge clk);
        checkOutput("rstFirstPixel", px_addr, FB_BASE);
        @(negedge clk);
        checkOutput("rstSecondPixel", px_addr, FB_BASE + 32'd4);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstNoValid", 32'(px_valid), 32'd0);
        checkOutput("rstReady", 32'(line_ready), 32'd1);
        checkOutput("rstAddr", px_addr, 32'd0);
        checkOutput("rstColor", 32'(px_color), 32'd0);
        rst = 1'b0;
        px_ready = 1'b0;
        // Cleared registers redraw as a single black pixel at the origin.
        applyStimulus(0, 0, 0, 0, 24'h000000, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        px_ready = 1'b0;
        line_color = 32'd0;
        line_point = 10'd0;
        clearStrobes();
        repeat (3) @(negedge clk);
        checkOutput("resetReady", 32'(line_ready), 32'd1);
        checkOutput("resetValid", 32'(px_valid), 32'd0);
        checkOutput("resetAddr", px_addr, 32'd0);
        checkOutput("resetColor", 32'(px_color), 32'd0);
        rst = 1'b0;

        applyStimulus(0, 0, 3, 0, 24'hFF0000, 0, 1'b0, 1'b1);
        applyStimulus(0, 0, 1, 3, 24'h00FF00, 0, 1'b0, 1'b1);
        applyStimulus(3, 2, 0, 2, 24'h0000FF, 0, 1'b0, 1'b1);
        applyStimulus(0, 0, 3, 0, 24'hFF0000, 1, 1'b1, 1'b1);
        applyStimulus(0, 0, 3, 0, 24'hFF0000, 1, 1'b0, 1'b0);
        applyStimulus(5, 5, 5, 5, 24'h123456, 0, 1'b0, 1'b1);
        applyStimulus(7, 20, 2, 3, 24'hABCDEF, 2, 1'b0, 1'b1);
        applyStimulus(798, 0, 801, 0, 24'h777777, 0, 1'b0, 1'b1);

        for (int n = 0; n < 12; n++) begin
            applyStimulus(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                          int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                          24'($urandom), 2, 1'b0, 1'b1);
        end

        resetMidLine();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
